// File: rtl/mips_mem_pkg.sv
// Shared types and the address decoder for the MIPS Avalon-style memory.
package mips_mem_pkg;

    typedef enum logic [0:0] {IDLE, STALL} mem_state_t;

    typedef enum logic [1:0] {REG_DATA, REG_INSTR, REG_NONE} region_t;

    typedef enum logic [1:0] {SEL_ZERO, SEL_DATA, SEL_INSTR} rsel_t;

    typedef struct packed {
        region_t     region;
        logic [31:0] offset;
    } addr_map_t;

    localparam logic [31:0] ERR_READ_DATA = 32'h0;

    // Offset is the unified offset: instruction bytes sit after the data bytes.
    function automatic addr_map_t map_addr(input logic [31:0] address,
                                           input logic [31:0] data_bytes,
                                           input logic [31:0] instr_base,
                                           input logic [31:0] instr_bytes);
        addr_map_t   m;
        logic [32:0] instr_end;
        instr_end = {1'b0, instr_base} + {1'b0, instr_bytes};
        m.region  = REG_NONE;
        m.offset  = 32'h0;
        if (address < data_bytes) begin
            m.region = REG_DATA;
            m.offset = address;
        end else if (address >= instr_base && {1'b0, address} < instr_end) begin
            m.region = REG_INSTR;
            m.offset = address - instr_base + data_bytes;
        end
        return m;
    endfunction

endpackage

// File: rtl/mips_mem_avalon_bytebank.sv
// Byte-addressed storage with four big-endian write lanes and a registered word read.
module mips_mem_bytebank #(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-3:0] i_waddr,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    output logic [31:0]   o_rdata
);

    logic [7:0]  r_mem [DEPTH];
    logic [31:0] r_q;

    initial begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] = 8'h00;
    end

    // Lane i carries writedata[8i+7:8i] and lands at byte 3-i of the word.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we && i_be[i]) r_mem[{i_waddr, 2'(3 - i)}] <= i_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_q <= {r_mem[{i_waddr, 2'd0}], r_mem[{i_waddr, 2'd1}],
                    r_mem[{i_waddr, 2'd2}], r_mem[{i_waddr, 2'd3}]};
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/mips_mem_avalon.sv
// Two-region word memory with wait states, registered read response and error pulses.
module mips_mem_avalon
    import mips_mem_pkg::*;
#(
    parameter int          DATA_BYTES      = 1024,
    parameter int          INSTR_BYTES     = 1024,
    parameter logic [31:0] INSTR_BASE      = 32'hBFC00000,
    parameter int          WAIT_CYCLES     = 0,
    parameter string       DATA_INIT_FILE  = "",
    parameter string       INSTR_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        bus_error
);

    localparam int          DAW        = $clog2(DATA_BYTES);
    localparam int          IAW        = $clog2(INSTR_BYTES);
    localparam logic [3:0]  STALL_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mem_state_t  r_state;
    logic [3:0]  r_count;
    rsel_t       r_rsel;
    logic        r_rdvalid;
    logic        r_buserr;

    addr_map_t   w_map;
    logic [31:0] w_ioff;
    logic        w_req;
    logic        w_accept;
    logic        w_wait;
    logic        w_err;
    logic        w_ok;
    logic [31:0] w_dq;
    logic [31:0] w_iq;
    logic        w_unused;

    assign w_map  = map_addr(address, 32'(DATA_BYTES), INSTR_BASE, 32'(INSTR_BYTES));
    assign w_ioff = w_map.offset - 32'(DATA_BYTES);
    assign w_req  = read | write;
    assign w_err  = (read & write) | (address[1:0] != 2'b00) | (w_map.region == REG_NONE);
    assign w_ok   = w_accept & ~w_err;

    // Reset overrides acceptance so an access caught mid-stall never commits.
    always_comb begin
        w_wait   = 1'b0;
        w_accept = 1'b0;
        if (w_req) begin
            case (r_state)
                IDLE: begin
                    if (WAIT_CYCLES == 0) w_accept = 1'b1;
                    else                  w_wait   = 1'b1;
                end
                STALL: begin
                    if (r_count != 4'd0) w_wait   = 1'b1;
                    else                 w_accept = 1'b1;
                end
                default: ;
            endcase
        end
        if (reset) w_accept = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            r_rsel    <= SEL_ZERO;
            r_rdvalid <= 1'b0;
            r_buserr  <= 1'b0;
        end else begin
            r_rdvalid <= w_accept & read;
            r_buserr  <= w_accept & w_err;
            if (w_accept && read) begin
                if (w_err)                       r_rsel <= SEL_ZERO;
                else if (w_map.region == REG_INSTR) r_rsel <= SEL_INSTR;
                else                             r_rsel <= SEL_DATA;
            end
            case (r_state)
                IDLE: begin
                    if (w_req && WAIT_CYCLES != 0) begin
                        r_state <= STALL;
                        r_count <= STALL_INIT;
                    end
                end
                STALL: begin
                    if (!w_req || r_count == 4'd0) r_state <= IDLE;
                    else                           r_count <= r_count - 4'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mips_mem_bytebank #(
        .DEPTH     (DATA_BYTES),
        .INIT_FILE (DATA_INIT_FILE)
    ) u_data (
        .clk     (clk),
        .i_waddr (w_map.offset[DAW-1:2]),
        .i_we    (w_ok & write & (w_map.region == REG_DATA)),
        .i_be    (byteenable),
        .i_wdata (writedata),
        .i_re    (w_ok & read & (w_map.region == REG_DATA)),
        .o_rdata (w_dq)
    );

    mips_mem_bytebank #(
        .DEPTH     (INSTR_BYTES),
        .INIT_FILE (INSTR_INIT_FILE)
    ) u_instr (
        .clk     (clk),
        .i_waddr (w_ioff[IAW-1:2]),
        .i_we    (w_ok & write & (w_map.region == REG_INSTR)),
        .i_be    (byteenable),
        .i_wdata (writedata),
        .i_re    (w_ok & read & (w_map.region == REG_INSTR)),
        .o_rdata (w_iq)
    );

    assign w_unused = ^{w_map.offset[31:DAW], w_map.offset[1:0], w_ioff[31:IAW], w_ioff[1:0]};

    assign waitrequest   = w_wait;
    assign readdatavalid = r_rdvalid;
    assign bus_error     = r_buserr;
    assign readdata      = (r_rsel == SEL_DATA)  ? w_dq :
                           (r_rsel == SEL_INSTR) ? w_iq : ERR_READ_DATA;

endmodule

// File: tb/tb_mips_mem_avalon.sv
// Bench: three memories (0, 3 and 2 wait states) checked each cycle against a byte-map model.
module tb_mips_mem_avalon;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic [31:0] addr [3];
    logic        rd   [3];
    logic        wr   [3];
    logic [3:0]  be   [3];
    logic [31:0] wd   [3];
    logic        wreq [3];
    logic [31:0] rdat [3];
    logic        rdv  [3];
    logic        berr [3];

    int n_vec = 0;
    int n_err = 0;

    mips_mem_avalon #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
        .byteenable(be[0]), .writedata(wd[0]), .waitrequest(wreq[0]),
        .readdata(rdat[0]), .readdatavalid(rdv[0]), .bus_error(berr[0]));

    mips_mem_avalon #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
        .byteenable(be[1]), .writedata(wd[1]), .waitrequest(wreq[1]),
        .readdata(rdat[1]), .readdatavalid(rdv[1]), .bus_error(berr[1]));

    mips_mem_avalon #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(rst[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
        .byteenable(be[2]), .writedata(wd[2]), .waitrequest(wreq[2]),
        .readdata(rdat[2]), .readdatavalid(rdv[2]), .bus_error(berr[2]));

    function automatic void chk(input string nm, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
        end
    endfunction

    // ---------------- model ----------------
    logic [7:0]  mmem [logic [33:0]];
    int          m_waited [3];
    logic        m_vld    [3];
    logic        m_err    [3];
    logic [31:0] m_rdata  [3];
    bit          m_live   [3];

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic bit mapped(input logic [31:0] a);
        return (a < 32'd1024) || (a >= 32'hBFC00000 && (a - 32'hBFC00000) < 32'd1024);
    endfunction

    function automatic logic [7:0] mbyte(input int k, input logic [31:0] a);
        logic [33:0] key;
        key = {k[1:0], a};
        return mmem.exists(key) ? mmem[key] : 8'h00;
    endfunction

    always @(negedge clk) begin : cmp
        bit   req;
        bit   expw;
        bit   bad;
        logic [31:0] a;
        for (int k = 0; k < 3; k++) begin
            if (m_live[k]) begin
                chk("readdatavalid", k, 32'(rdv[k]),  32'(m_vld[k]));
                chk("bus_error",     k, 32'(berr[k]), 32'(m_err[k]));
                chk("readdata",      k, rdat[k],      m_rdata[k]);
            end
            req      = rd[k] | wr[k];
            m_vld[k] = 1'b0;
            m_err[k] = 1'b0;
            if (rst[k]) begin
                m_live[k]   = 1'b1;
                m_waited[k] = 0;
                m_rdata[k]  = 32'h0;
            end else if (m_live[k]) begin
                expw = req && (m_waited[k] < wait_of(k));
                chk("waitrequest", k, 32'(wreq[k]), 32'(expw));
                if (req && !expw) begin
                    a   = addr[k];
                    bad = (rd[k] && wr[k]) || (a[1:0] != 2'b00) || !mapped(a);
                    if (rd[k]) begin
                        m_vld[k]   = 1'b1;
                        m_rdata[k] = bad ? 32'h0 :
                                     {mbyte(k, a), mbyte(k, a + 1), mbyte(k, a + 2), mbyte(k, a + 3)};
                    end
                    m_err[k] = bad;
                    if (wr[k] && !bad) begin
                        for (int i = 0; i < 4; i++)
                            if (be[k][i]) mmem[{k[1:0], a + 32'(3 - i)}] = wd[k][8*i +: 8];
                    end
                    m_waited[k] = 0;
                end else if (req) begin
                    m_waited[k]++;
                end else begin
                    m_waited[k] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          output logic [31:0] q, output logic e, output logic v,
                          output int waits);
        int n;
        @(posedge clk); #1;
        rd[k] = r; wr[k] = w; addr[k] = a; be[k] = b; wd[k] = d;
        waits = 0;
        n     = 0;
        @(negedge clk);
        while (wreq[k] === 1'b1 && n < 40) begin
            waits++;
            n++;
            @(negedge clk);
        end
        if (n >= 40) chk("accept_timeout", k, 32'(n), 32'd0);
        @(posedge clk); #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
        @(negedge clk);
        q = rdat[k];
        e = berr[k];
        v = rdv[k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] q;
        logic        e;
        logic        v;
        int          ws;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; addr[k] = 32'h0; rd[k] = 1'b0; wr[k] = 1'b0;
            be[k] = 4'h0; wd[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        chk("reset_readdata", 0, rdat[0], 32'h0);
        chk("reset_valid",    0, 32'(rdv[0]), 32'd0);

        // Zero wait states: full write then read.
        access(0, 0, 1, 32'h10, 4'hF, 32'h11223344, q, e, v, ws);
        chk("w10_err", 0, 32'(e), 32'd0);
        chk("w10_waits", 0, 32'(ws), 32'd0);
        access(0, 1, 0, 32'h10, 4'h0, 32'h0, q, e, v, ws);
        chk("r10_data", 0, q, 32'h11223344);
        chk("r10_valid", 0, 32'(v), 32'd1);
        chk("r10_waits", 0, 32'(ws), 32'd0);

        // Lane 1 lands at byte offset 2.
        access(0, 0, 1, 32'h10, 4'b0010, 32'h0000AB00, q, e, v, ws);
        access(0, 1, 0, 32'h10, 4'h0, 32'h0, q, e, v, ws);
        chk("partial_data", 0, q, 32'h1122AB44);
        access(0, 1, 0, 32'h10, 4'hF, 32'h0, q, e, v, ws);
        chk("partial_byte12", 0, 32'(q[15:8]), 32'hAB);

        // Write with no lanes enabled is a legal no-op.
        access(0, 0, 1, 32'h10, 4'h0, 32'hFFFFFFFF, q, e, v, ws);
        chk("be0_err", 0, 32'(e), 32'd0);
        access(0, 1, 0, 32'h10, 4'h0, 32'h0, q, e, v, ws);
        chk("be0_data", 0, q, 32'h1122AB44);

        // Error cases.
        access(0, 0, 1, 32'h20, 4'hF, 32'hA5A55A5A, q, e, v, ws);
        access(0, 1, 0, 32'h402, 4'h0, 32'h0, q, e, v, ws);
        chk("misalign_err", 0, 32'(e), 32'd1);
        chk("misalign_vld", 0, 32'(v), 32'd1);
        chk("misalign_data", 0, q, 32'h0);
        access(0, 1, 0, 32'h80000000, 4'h0, 32'h0, q, e, v, ws);
        chk("unmapped_err", 0, 32'(e), 32'd1);
        chk("unmapped_data", 0, q, 32'h0);
        access(0, 1, 1, 32'h20, 4'hF, 32'hFFFFFFFF, q, e, v, ws);
        chk("rdwr_err", 0, 32'(e), 32'd1);
        chk("rdwr_vld", 0, 32'(v), 32'd1);
        chk("rdwr_data", 0, q, 32'h0);
        access(0, 1, 0, 32'h20, 4'h0, 32'h0, q, e, v, ws);
        chk("r20_unchanged", 0, q, 32'hA5A55A5A);

        // Region boundaries.
        access(0, 0, 1, 32'h3FC, 4'hF, 32'hDEADBEEF, q, e, v, ws);
        access(0, 0, 1, 32'hBFC003FC, 4'hF, 32'h0BADF00D, q, e, v, ws);
        access(0, 1, 0, 32'h3FC, 4'h0, 32'h0, q, e, v, ws);
        chk("r3fc_data", 0, q, 32'hDEADBEEF);
        access(0, 1, 0, 32'hBFC003FC, 4'h0, 32'h0, q, e, v, ws);
        chk("rbfc3fc_data", 0, q, 32'h0BADF00D);
        access(0, 0, 1, 32'h400, 4'hF, 32'h12345678, q, e, v, ws);
        chk("w400_err", 0, 32'(e), 32'd1);
        chk("w400_vld", 0, 32'(v), 32'd0);
        access(0, 1, 0, 32'hBFC00400, 4'h0, 32'h0, q, e, v, ws);
        chk("rbfc400_err", 0, 32'(e), 32'd1);

        // Three wait states on the instruction region.
        access(1, 0, 1, 32'hBFC00000, 4'hF, 32'h24020005, q, e, v, ws);
        chk("w3_write_waits", 1, 32'(ws), 32'd3);
        access(1, 1, 0, 32'hBFC00000, 4'h0, 32'h0, q, e, v, ws);
        chk("w3_read_waits", 1, 32'(ws), 32'd3);
        chk("w3_read_data", 1, q, 32'h24020005);
        chk("w3_read_vld", 1, 32'(v), 32'd1);

        // Reset in the second stall cycle aborts the write.
        access(2, 0, 1, 32'h30, 4'hF, 32'hCAFEF00D, q, e, v, ws);
        chk("w2_waits", 2, 32'(ws), 32'd2);
        @(posedge clk); #1;
        rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h30; be[2] = 4'hF; wd[2] = 32'h12345678;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0; wr[2] = 1'b0;
        @(negedge clk);
        chk("post_reset_vld", 2, 32'(rdv[2]), 32'd0);
        chk("post_reset_err", 2, 32'(berr[2]), 32'd0);
        repeat (2) @(posedge clk);
        access(2, 1, 0, 32'h30, 4'h0, 32'h0, q, e, v, ws);
        chk("r30_old", 2, q, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
